// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline stall/flush sequencer for the 5-stage integer core
//
// Purpose: resolves hazards the forwarding unit cannot. These are load-use
// (with multi-cycle load latency), mul/div occupancy of EX and taken-branch
// redirects. It drives the hold/bubble/flush controls and keeps a saturating
// count of stalled cycles.
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_rs1_id, i_rs2_id       ID-stage source registers
//   i_uses_rs1_id/rs2_id     ID instruction actually reads rs1/rs2
//   i_rd_ex, i_mem_read_ex   EX destination and load flag
//   i_md_start_ex, i_md_done mul/div issue pulse and result-valid
//   i_branch_taken_ex        EX resolved a taken branch/jump
//   i_perf_clr               synchronous clear of o_stall_cycles
//   o_stall_if/id/ex         hold controls
//   o_bubble_ex/mem          NOP injection into ID/EX, EX/MEM
//   o_flush_if_id/id_ex      invalidate IF/ID, ID/EX
//   o_md_busy                sequencer is waiting on mul/div
//   o_stall_cycles           saturating count of cycles with o_stall_if=1
module hazard_stall_controller #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_rs1_id,
  input  logic [4:0]       i_rs2_id,
  input  logic             i_uses_rs1_id,
  input  logic             i_uses_rs2_id,
  input  logic [4:0]       i_rd_ex,
  input  logic             i_mem_read_ex,
  input  logic             i_md_start_ex,
  input  logic             i_md_done,
  input  logic             i_branch_taken_ex,
  input  logic             i_perf_clr,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_bubble_ex,
  output logic             o_bubble_mem,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_md_busy,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_LSTALL  = 2'd1;
  localparam logic [1:0] S_MD_WAIT = 2'd2;

  // The cycle that detects the hazard is the first stall cycle. LSTALL then
  // covers the remaining LOAD_LAT-1 cycles, counting down to zero inclusive.
  localparam logic [2:0] LCNT_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [2:0]       r_lcnt;
  logic [2:0]       w_lcnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_lu_hit;

  assign w_lu_hit = i_mem_read_ex && (i_rd_ex != 5'd0) &&
                    ((i_uses_rs1_id && (i_rs1_id == i_rd_ex)) ||
                     (i_uses_rs2_id && (i_rs2_id == i_rd_ex)));

  always_comb begin
    w_state_nxt   = r_state;
    w_lcnt_nxt    = r_lcnt;
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_stall_ex    = 1'b0;
    o_bubble_ex   = 1'b0;
    o_bubble_mem  = 1'b0;
    o_flush_if_id = 1'b0;
    o_flush_id_ex = 1'b0;
    case (r_state)
      S_RUN: begin
        if (i_branch_taken_ex) begin
          o_flush_if_id = 1'b1;
          o_flush_id_ex = 1'b1;
        end else if (i_md_start_ex && !i_md_done) begin
          o_stall_if   = 1'b1;
          o_stall_id   = 1'b1;
          o_stall_ex   = 1'b1;
          o_bubble_mem = 1'b1;
          w_state_nxt  = S_MD_WAIT;
        end else if (i_md_start_ex) begin
          // Single-cycle mul/div: nothing to hold. This also shields a
          // simultaneous mem_read_ex, since md_start_ex has precedence.
          w_state_nxt = S_RUN;
        end else if (w_lu_hit) begin
          o_stall_if  = 1'b1;
          o_stall_id  = 1'b1;
          o_bubble_ex = 1'b1;
          if (LOAD_LAT > 1) begin
            w_lcnt_nxt  = LCNT_INIT;
            w_state_nxt = S_LSTALL;
          end
        end
      end
      S_LSTALL: begin
        // EX holds a bubble here, so hazard and branch inputs are meaningless.
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_bubble_ex = 1'b1;
        if (r_lcnt == 3'd0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_lcnt_nxt = r_lcnt - 3'd1;
        end
      end
      S_MD_WAIT: begin
        if (!i_md_done) begin
          o_stall_if   = 1'b1;
          o_stall_id   = 1'b1;
          o_stall_ex   = 1'b1;
          o_bubble_mem = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
      r_lcnt  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_lcnt  <= w_lcnt_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
    end else if (i_perf_clr) begin
      r_stall_cycles <= '0;
    end else if (o_stall_if && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_md_busy      = (r_state == S_MD_WAIT);
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed-vector bench for hazard_stall_controller
module tb_hazard_stall_controller;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       uses_rs1_id, uses_rs2_id, mem_read_ex;
  logic       md_start_ex, md_done, branch_taken_ex, perf_clr;

  // Two instances share the stimulus: a is LOAD_LAT=1/CNT_W=16, b is LOAD_LAT=3/CNT_W=4.
  logic        a_sif, a_sid, a_sex, a_bex, a_bmem, a_fifid, a_fidex, a_busy;
  logic [15:0] a_cnt;
  logic        b_sif, b_sid, b_sex, b_bex, b_bmem, b_fifid, b_fidex, b_busy;
  logic [3:0]  b_cnt;

  // Output vector order: {stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_if_id, flush_id_ex}
  logic [6:0] a_out, b_out;
  assign a_out = {a_sif, a_sid, a_sex, a_bex, a_bmem, a_fifid, a_fidex};
  assign b_out = {b_sif, b_sid, b_sex, b_bex, b_bmem, b_fifid, b_fidex};

  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_LOAD  = 7'b1101000;
  localparam logic [6:0] O_MD    = 7'b1110100;
  localparam logic [6:0] O_FLUSH = 7'b0000011;

  hazard_stall_controller #(.LOAD_LAT(1), .CNT_W(16)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_id(rs1_id), .i_rs2_id(rs2_id),
    .i_uses_rs1_id(uses_rs1_id), .i_uses_rs2_id(uses_rs2_id),
    .i_rd_ex(rd_ex), .i_mem_read_ex(mem_read_ex),
    .i_md_start_ex(md_start_ex), .i_md_done(md_done),
    .i_branch_taken_ex(branch_taken_ex), .i_perf_clr(perf_clr),
    .o_stall_if(a_sif), .o_stall_id(a_sid), .o_stall_ex(a_sex),
    .o_bubble_ex(a_bex), .o_bubble_mem(a_bmem),
    .o_flush_if_id(a_fifid), .o_flush_id_ex(a_fidex),
    .o_md_busy(a_busy), .o_stall_cycles(a_cnt)
  );

  hazard_stall_controller #(.LOAD_LAT(3), .CNT_W(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_id(rs1_id), .i_rs2_id(rs2_id),
    .i_uses_rs1_id(uses_rs1_id), .i_uses_rs2_id(uses_rs2_id),
    .i_rd_ex(rd_ex), .i_mem_read_ex(mem_read_ex),
    .i_md_start_ex(md_start_ex), .i_md_done(md_done),
    .i_branch_taken_ex(branch_taken_ex), .i_perf_clr(perf_clr),
    .o_stall_if(b_sif), .o_stall_id(b_sid), .o_stall_ex(b_sex),
    .o_bubble_ex(b_bex), .o_bubble_mem(b_bmem),
    .o_flush_if_id(b_fifid), .o_flush_id_ex(b_fidex),
    .o_md_busy(b_busy), .o_stall_cycles(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    uses_rs1_id = 1'b0; uses_rs2_id = 1'b0; mem_read_ex = 1'b0;
    md_start_ex = 1'b0; md_done = 1'b0; branch_taken_ex = 1'b0; perf_clr = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well clear of either edge.
  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic load_use_rs2();
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; uses_rs2_id = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #2;
    settle();
    check("rst_out_a", 32'(a_out), 32'(O_IDLE));
    check("rst_out_b", 32'(b_out), 32'(O_IDLE));
    check("rst_busy_a", 32'(a_busy), 32'd0);
    check("rst_cnt_a", 32'(a_cnt), 32'd0);
    check("rst_cnt_b", 32'(b_cnt), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    settle();
    check("idle_out_a", 32'(a_out), 32'(O_IDLE));
    check("idle_out_b", 32'(b_out), 32'(O_IDLE));

    // Load-use with LOAD_LAT=1: exactly one stall cycle.
    cyc(); load_use_rs2(); settle();
    check("lu1_t0", 32'(a_out), 32'(O_LOAD));
    cyc(); idle_inputs(); settle();
    check("lu1_t1", 32'(a_out), 32'(O_IDLE));
    check("lu1_cnt", 32'(a_cnt), 32'd1);
    // rd_ex = x0 never creates a hazard.
    cyc(); load_use_rs2(); rd_ex = 5'd0; rs2_id = 5'd0; settle();
    check("lu_x0", 32'(a_out), 32'(O_IDLE));
    cyc(); do_reset();

    // Load-use with LOAD_LAT=3; noisy inputs during LSTALL are ignored.
    load_use_rs2(); settle();
    check("lu3_t0", 32'(b_out), 32'(O_LOAD));
    cyc();
    idle_inputs();
    branch_taken_ex = 1'b1; md_start_ex = 1'b1;
    mem_read_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; uses_rs1_id = 1'b1;
    settle();
    check("lu3_t1", 32'(b_out), 32'(O_LOAD));
    check("lu3_t1_busy", 32'(b_busy), 32'd0);
    cyc(); settle();
    check("lu3_t2", 32'(b_out), 32'(O_LOAD));
    cyc(); idle_inputs(); settle();
    check("lu3_t3", 32'(b_out), 32'(O_IDLE));
    check("lu3_cnt", 32'(b_cnt), 32'd3);
    check("lu3_busy", 32'(b_busy), 32'd0);
    cyc(); do_reset();

    // Mul/div started at t, done at t+4, branch pulse at t+2 ignored.
    md_start_ex = 1'b1; settle();
    check("md_t0", 32'(a_out), 32'(O_MD));
    check("md_t0_busy", 32'(a_busy), 32'd0);
    cyc(); md_start_ex = 1'b0; settle();
    check("md_t1", 32'(a_out), 32'(O_MD));
    check("md_t1_busy", 32'(a_busy), 32'd1);
    cyc(); branch_taken_ex = 1'b1; settle();
    check("md_t2_nobranch", 32'(a_out), 32'(O_MD));
    cyc(); branch_taken_ex = 1'b0; settle();
    check("md_t3", 32'(b_out), 32'(O_MD));
    cyc(); md_done = 1'b1; settle();
    check("md_t4", 32'(a_out), 32'(O_IDLE));
    check("md_t4_busy", 32'(a_busy), 32'd1);
    cyc(); md_done = 1'b0; settle();
    check("md_t5_busy", 32'(a_busy), 32'd0);
    check("md_cnt", 32'(a_cnt), 32'd4);
    // Single-cycle mul/div: no stall at all.
    cyc(); md_start_ex = 1'b1; md_done = 1'b1; settle();
    check("md_fast", 32'(a_out), 32'(O_IDLE));
    cyc(); idle_inputs(); settle();
    check("md_fast_busy", 32'(a_busy), 32'd0);
    check("md_fast_cnt", 32'(a_cnt), 32'd4);

    // Branch outranks a live load-use hazard.
    cyc(); load_use_rs2(); branch_taken_ex = 1'b1; settle();
    check("br_a", 32'(a_out), 32'(O_FLUSH));
    check("br_b", 32'(b_out), 32'(O_FLUSH));
    cyc(); idle_inputs(); settle();
    check("br_after_a", 32'(a_out), 32'(O_IDLE));
    check("br_after_b", 32'(b_out), 32'(O_IDLE));
    check("br_cnt", 32'(a_cnt), 32'd4);
    cyc(); do_reset();

    // Reset in the middle of MD_WAIT.
    md_start_ex = 1'b1;
    cyc(); md_start_ex = 1'b0;
    cyc(); settle();
    check("mdrst_pre", 32'(a_out), 32'(O_MD));
    cyc(); rst_n = 1'b0; #1;
    check("mdrst_out", 32'(a_out), 32'(O_IDLE));
    check("mdrst_busy", 32'(a_busy), 32'd0);
    check("mdrst_cnt", 32'(a_cnt), 32'd0);
    cyc(); rst_n = 1'b1; settle();
    check("mdrst_rel", 32'(b_out), 32'(O_IDLE));
    cyc(); settle();
    check("mdrst_rel2", 32'(a_out), 32'(O_IDLE));

    // 20 stalled cycles: CNT_W=4 saturates at 15, CNT_W=16 reaches 20.
    cyc(); md_start_ex = 1'b1;
    cyc(); md_start_ex = 1'b0;
    for (int i = 0; i < 18; i++) cyc();
    settle();
    check("sat_last_stall", 32'(b_out), 32'(O_MD));
    cyc(); md_done = 1'b1; settle();
    check("sat_cnt_b", 32'(b_cnt), 32'd15);
    check("sat_cnt_a", 32'(a_cnt), 32'd20);
    // Clear while stalling: clear wins over increment.
    cyc(); md_done = 1'b0; md_start_ex = 1'b1; perf_clr = 1'b1; settle();
    check("clr_stall", 32'(b_out), 32'(O_MD));
    cyc(); md_start_ex = 1'b0; perf_clr = 1'b0; md_done = 1'b1; settle();
    check("clr_cnt_b", 32'(b_cnt), 32'd0);
    check("clr_cnt_a", 32'(a_cnt), 32'd0);
    cyc(); idle_inputs(); settle();
    check("clr_busy", 32'(b_busy), 32'd0);
    check("clr_hold", 32'(b_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
